digital_pattern_generator: RTL and testbench

Generator-side counterpart of the digital acquisition path. It plays a stored pattern memory onto NUM_SIGNALS digital outputs, driving the MSO signal-generator function. Each sample is held for a programmable number of clocks, which is the inverse of acquisition decimation. The block emits a trigger pulse at the start of every pattern pass so the acquisition side can lock to generated stimulus.

---
 rtl/digital_pattern_generator.sv | 200 ++++++++++++++++++++
 tb/tb_digital_pattern_generator.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/digital_pattern_generator.sv
// ---------------------------------------------------------------------------
// digital_pattern_generator
//
// Plays a stored pattern memory onto NUM_SIGNALS registered outputs. Each
// sample is held for divider+1 clocks. A pass covers indices 0..length.
// Playback either wraps forever (continuous=1) or runs a single pass and then
// returns to IDLE (continuous=0).
//
// Ports
//   clk, rst         system clock; synchronous active-high reset
//   wr_en/addr/data  pattern memory write port, accepted in any state
//   length           index of the last sample; a pass is length+1 samples
//   divider          each sample is held for divider+1 clocks
//   continuous       1 = wrap forever, 0 = single pass
//   start, stop      start playback from IDLE; stop aborts RUN (stop wins)
//   out              generated signals (registered)
//   strobe           one-cycle pulse whenever out takes a new sample
//   trigger          one-cycle pulse whenever out takes sample index 0
//   busy             high while the FSM is in RUN
//   done             one-cycle pulse at the natural end of a single pass
//
// Handshake semantics: start and stop are level inputs sampled on every
// rising edge. The strobe, trigger and done outputs are single-cycle pulses
// and have no back-pressure.
//
// Timing, with start sampled at edge T: the memory read of index 0 is issued
// at T. busy is visible after T. out=mem[0] with strobe and trigger is
// visible after T+1. The read of the following sample is always issued on the
// edge that loads the current one, so there are no gaps between samples.
// ---------------------------------------------------------------------------
module digital_pattern_generator #(
  parameter int NUM_SIGNALS = 8,
  parameter int DEPTH_BITS  = 8,
  parameter int DIV_BITS    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DEPTH_BITS-1:0]  wr_addr,
  input  logic [NUM_SIGNALS-1:0] wr_data,
  input  logic [DEPTH_BITS-1:0]  length,
  input  logic [DIV_BITS-1:0]    divider,
  input  logic                   continuous,
  input  logic                   start,
  input  logic                   stop,
  output logic [NUM_SIGNALS-1:0] out,
  output logic                   strobe,
  output logic                   trigger,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [DEPTH_BITS-1:0]  len_q, len_d;
  logic [DIV_BITS-1:0]    div_q, div_d;
  logic                   cont_q, cont_d;
  // first_q marks the cycle in which mem[0] has been read but is not yet shown.
  logic                   first_q, first_d;
  // cur_idx_q is the index currently driven on out.
  logic [DEPTH_BITS-1:0]  cur_idx_q, cur_idx_d;
  logic [DIV_BITS-1:0]    hold_q, hold_d;
  logic [NUM_SIGNALS-1:0] out_q, out_d;
  logic                   strobe_q, strobe_d;
  logic                   trigger_q, trigger_d;
  logic                   done_q, done_d;

  // Pattern RAM: one write port and one synchronous read port. There is no
  // reset, so the RAM maps onto block RAM and keeps its contents across rst.
  logic [NUM_SIGNALS-1:0] mem_q [0:(1<<DEPTH_BITS)-1];
  logic [NUM_SIGNALS-1:0] rd_data_q;
  logic                   rd_en;
  logic [DEPTH_BITS-1:0]  rd_addr;

  // Index of the sample loaded on the next sample boundary.
  logic [DEPTH_BITS-1:0]  load_idx;

  // Next index within a pass. The index wraps at 'last', so it never exceeds
  // length.
  function automatic logic [DEPTH_BITS-1:0] next_idx(
    input logic [DEPTH_BITS-1:0] idx,
    input logic [DEPTH_BITS-1:0] last
  );
    return (idx == last) ? '0 : idx + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    // Read-before-write: a read and a write to the same address in the same
    // cycle return the old word.
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    div_d     = div_q;
    cont_d    = cont_q;
    first_d   = first_q;
    cur_idx_d = cur_idx_q;
    hold_d    = hold_q;
    out_d     = out_q;
    strobe_d  = 1'b0;
    trigger_d = 1'b0;
    done_d    = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    load_idx  = first_q ? '0 : next_idx(cur_idx_q, len_q);

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d   = RUN;
          len_d     = length;
          div_d     = divider;
          cont_d    = continuous;
          first_d   = 1'b1;
          cur_idx_d = '0;
          hold_d    = '0;
          rd_en     = 1'b1;
          rd_addr   = '0;
        end
      end

      RUN: begin
        if (stop) begin
          // Abort: out keeps its current value and no pulses are generated.
          state_d = IDLE;
          first_d = 1'b0;
        end else if (first_q || (hold_q == div_q)) begin
          if (!first_q && (cur_idx_q == len_q) && !cont_q) begin
            // End of a single pass. This is the cycle in which the next
            // sample would otherwise have appeared.
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            out_d     = rd_data_q;
            cur_idx_d = load_idx;
            strobe_d  = 1'b1;
            trigger_d = (load_idx == '0);
            hold_d    = '0;
            first_d   = 1'b0;
            // Prefetch the sample that follows the one loaded now.
            rd_en     = 1'b1;
            rd_addr   = next_idx(load_idx, len_q);
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      div_q     <= '0;
      cont_q    <= 1'b0;
      first_q   <= 1'b0;
      cur_idx_q <= '0;
      hold_q    <= '0;
      out_q     <= '0;
      strobe_q  <= 1'b0;
      trigger_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      div_q     <= div_d;
      cont_q    <= cont_d;
      first_q   <= first_d;
      cur_idx_q <= cur_idx_d;
      hold_q    <= hold_d;
      out_q     <= out_d;
      strobe_q  <= strobe_d;
      trigger_q <= trigger_d;
      done_q    <= done_d;
    end
  end

  assign out     = out_q;
  assign strobe  = strobe_q;
  assign trigger = trigger_q;
  assign done    = done_q;
  assign busy    = (state_q == RUN);

endmodule

// File: tb/tb_digital_pattern_generator.sv
module tb_digital_pattern_generator;
  localparam int NS  = 8;
  localparam int DB  = 8;
  localparam int DVB = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           wr_en;
  logic [DB-1:0]  wr_addr;
  logic [NS-1:0]  wr_data;
  logic [DB-1:0]  length;
  logic [DVB-1:0] divider;
  logic           continuous;
  logic           start;
  logic           stop;
  logic [NS-1:0]  out;
  logic           strobe;
  logic           trigger;
  logic           busy;
  logic           done;

  digital_pattern_generator #(.NUM_SIGNALS(NS), .DEPTH_BITS(DB), .DIV_BITS(DVB)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .length(length), .divider(divider), .continuous(continuous),
    .start(start), .stop(stop), .out(out), .strobe(strobe), .trigger(trigger),
    .busy(busy), .done(done)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: memory image and the last value shown on out.
  logic [NS-1:0] ref_mem [0:255];
  logic [NS-1:0] ref_out;

  typedef struct {
    int          len;
    int          div;
    bit          cont;
    int          stop_k;
    int          cycles;
    int          exp_strobes;
    int          exp_trigs;
    int          exp_dones;
    logic [7:0]  exp_final;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Sample shown k cycles after the start edge, with the pass as a plain
  // sequence of samples, each repeated div+1 times.
  function automatic logic [NS-1:0] sample_at(int k, int len, int div, logic [NS-1:0] prev);
    if (k < 2) return prev;
    return ref_mem[((k - 2) / (div + 1)) % (len + 1)];
  endfunction

  // Expected {out, strobe, trigger, busy, done}, observed k cycles after the
  // start edge.
  function automatic logic [11:0] model(int k, int len, int div, bit cont, int stop_k,
                                       logic [NS-1:0] prev);
    int p = div + 1;
    int n = len + 1;
    int end_k = cont ? 32'h7fffffff : 2 + n * p;
    logic [NS-1:0] o;
    bit st, tr, bz, dn;
    st = 0; tr = 0; bz = 0; dn = 0;
    if (stop_k != 0 && k > stop_k) begin
      o = sample_at(stop_k, len, div, prev);
    end else if (!cont && k >= end_k) begin
      o  = ref_mem[len];
      dn = (k == end_k);
    end else begin
      o  = sample_at(k, len, div, prev);
      bz = 1;
      st = (k >= 2) && (((k - 2) % p) == 0);
      tr = st && ((((k - 2) / p) % n) == 0);
    end
    return {o, st, tr, bz, dn};
  endfunction

  // Driver tasks: each task is entered just after a falling edge; the
  // inputs it sets are sampled by the following rising edge.
  task automatic mem_write(input int a, input logic [NS-1:0] d);
    wr_en = 1; wr_addr = a[DB-1:0]; wr_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic idle_check(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(name, {out, strobe, trigger, busy, done}, {ref_out, 4'b0000});
    end
  endtask

  task automatic run(input int len, input int div, input bit cont, input int stop_k,
                     input int cycles, input int wr_k, input int wr_a,
                     input logic [NS-1:0] wr_d, input bit noise,
                     output int n_str, output int n_trg, output int n_done,
                     output logic [NS-1:0] fin);
    logic [NS-1:0] prev;
    logic [11:0]   exp;
    prev = ref_out;
    n_str = 0; n_trg = 0; n_done = 0; fin = prev;
    length = len[DB-1:0]; divider = div[DVB-1:0]; continuous = cont;
    start = 1; stop = 0;
    @(negedge clk);
    start = 0;
    for (int k = 1; k <= cycles; k++) begin
      exp = model(k, len, div, cont, stop_k, prev);
      check("run", {out, strobe, trigger, busy, done}, exp);
      n_str  += int'(strobe);
      n_trg  += int'(trigger);
      n_done += int'(done);
      fin = out;
      stop = (k == stop_k);
      if (k == wr_k) begin
        wr_en = 1; wr_addr = wr_a[DB-1:0]; wr_data = wr_d;
      end else begin
        wr_en = 0;
      end
      if (noise) begin
        // Latched settings must ignore later changes; start in RUN is ignored.
        length = DB'($urandom); divider = DVB'($urandom); continuous = 1'($urandom);
        start = exp[1] ? 1'($urandom) : 1'b0;
      end
      @(negedge clk);
      if (k == wr_k) ref_mem[wr_a] = wr_d;
    end
    start = 0; stop = 0; wr_en = 0;
    ref_out = exp[11:4];
  endtask

  vec_t vecs [6];

  initial begin
    int s, t, d;
    logic [NS-1:0] f;
    logic [11:0] exp;
    logic [NS-1:0] prev;

    vecs[0] = '{3, 0, 0, 0, 8, 4, 1, 1, 8'h08};
    vecs[1] = '{3, 2, 0, 0, 16, 4, 1, 1, 8'h08};
    vecs[2] = '{3, 0, 1, 8, 11, 7, 2, 0, 8'h04};
    vecs[3] = '{0, 0, 1, 6, 9, 5, 5, 0, 8'h01};
    vecs[4] = '{1, 1, 0, 0, 8, 2, 1, 1, 8'h02};
    vecs[5] = '{2, 3, 1, 12, 14, 3, 1, 0, 8'h04};

    rst = 1; wr_en = 0; wr_addr = '0; wr_data = '0; length = '0; divider = '0;
    continuous = 0; start = 0; stop = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 'x;
    ref_out = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_state", {out, strobe, trigger, busy, done}, 12'h000);
    rst = 0;

    mem_write(0, 8'h01);
    mem_write(1, 8'h02);
    mem_write(2, 8'h04);
    mem_write(3, 8'h08);

    // Table-driven directed runs
    for (int v = 0; v < 6; v++) begin
      run(vecs[v].len, vecs[v].div, vecs[v].cont, vecs[v].stop_k, vecs[v].cycles,
          0, 0, 8'h00, 0, s, t, d, f);
      check($sformatf("v%0d_strobes", v), s, vecs[v].exp_strobes);
      check($sformatf("v%0d_trigs", v), t, vecs[v].exp_trigs);
      check($sformatf("v%0d_dones", v), d, vecs[v].exp_dones);
      check($sformatf("v%0d_final", v), f, vecs[v].exp_final);
      idle_check($sformatf("v%0d_idle", v), 2);
    end

    // Single sample, continuous, divider 0, with start re-asserted in RUN
    mem_write(0, 8'hA5);
    run(0, 0, 1, 10, 12, 0, 0, 8'h00, 1, s, t, d, f);
    check("len0_strobes", s, 9);
    check("len0_trigs", t, 9);
    check("len0_final", f, 8'hA5);
    mem_write(0, 8'h01);

    // Reset in the middle of a continuous run
    prev = ref_out;
    length = 3; divider = 0; continuous = 1; start = 1; stop = 0;
    @(negedge clk);
    start = 0;
    for (int k = 1; k <= 4; k++) begin
      exp = model(k, 3, 0, 1, 0, prev);
      check("pre_rst", {out, strobe, trigger, busy, done}, exp);
      rst = (k == 4);
      @(negedge clk);
    end
    check("mid_rst", {out, strobe, trigger, busy, done}, 12'h000);
    rst = 0;
    ref_out = '0;
    run(3, 0, 0, 0, 8, 0, 0, 8'h00, 0, s, t, d, f);
    check("after_rst_final", f, 8'h08);
    check("after_rst_done", d, 1);

    // Write mem[2] while index 3 is on out; the next pass shows the new word
    run(3, 0, 1, 8, 10, 5, 2, 8'hFF, 0, s, t, d, f);
    check("wr_next_pass", f, 8'hFF);
    mem_write(2, 8'h04);

    // start and stop together in IDLE: stop wins
    start = 1; stop = 1;
    @(negedge clk);
    start = 0; stop = 0;
    idle_check("start_stop_idle", 3);

    // Randomized runs against the model
    for (int r = 0; r < 10; r++) begin
      int len, div, stop_k, end_k;
      bit cont;
      for (int w = 0; w < 4; w++) mem_write($urandom_range(0, 7), NS'($urandom));
      len  = $urandom_range(0, 7);
      div  = $urandom_range(0, 3);
      cont = 1'($urandom);
      end_k = 2 + (len + 1) * (div + 1);
      if (cont) begin
        stop_k = $urandom_range(1, 30);
        run(len, div, cont, stop_k, stop_k + 3, 0, 0, 8'h00, 1, s, t, d, f);
      end else begin
        stop_k = ($urandom_range(0, 2) == 0) ? $urandom_range(1, end_k - 1) : 0;
        run(len, div, cont, stop_k, end_k + 2, 0, 0, 8'h00, 1, s, t, d, f);
      end
      idle_check("rand_idle", 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
